// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Brief    : Single-port frame-buffer arbiter: display reads always win, and
//            buffered pixel writes (RGB332) fill the free cycles. Optional
//            clear engine when VRAM_ARBITER_CLEAR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
    parameter int ROWS       = 480,
    parameter int COLS       = 640,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        vga_clk,
    input  logic        rst,
`ifdef VRAM_ARBITER_CLEAR_EN
    input  logic        clr_start,
    input  logic [7:0]  clr_color,
    output logic        clr_busy,
`endif
    input  logic        disp_req,
    input  logic [8:0]  disp_row,
    input  logic [9:0]  disp_col,
    output logic [11:0] d_out,
    output logic        d_out_valid,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [8:0]  wr_row,
    input  logic [9:0]  wr_col,
    input  logic [7:0]  wr_data,
    output logic [8:0]  mem_row,
    output logic [9:0]  mem_col,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [4:0]  fifo_level,
    output logic [7:0]  drop_cnt
);
    localparam int               c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [8:0]       c_ROWS    = 9'(ROWS);
    localparam logic [9:0]       c_COLS    = 10'(COLS);
    localparam logic [4:0]       c_DEPTH   = 5'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;

    logic [26:0]        r_fifo_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d, r_rd_ptr_q, w_rd_ptr_d;
    logic [4:0]         r_level_q, w_level_d;
    logic [7:0]         r_drop_q, w_drop_d;
    logic               r_rd_v1_q, w_rd_v1_d, r_rd_v2_q, w_rd_v2_d;
    logic [11:0]        r_d_out_q, w_d_out_d;
    logic               r_d_out_valid_q, w_d_out_valid_d;
    logic [8:0]         r_mem_row_q, w_mem_row_d;
    logic [9:0]         r_mem_col_q, w_mem_col_d;
    logic               r_mem_we_q, w_mem_we_d;
    logic [7:0]         r_mem_wdata_q, w_mem_wdata_d;
    logic               w_xfer, w_in_range, w_push, w_drop, w_pop;
    logic [26:0]        w_head;

`ifdef VRAM_ARBITER_CLEAR_EN
    localparam logic [8:0] c_LAST_ROW = 9'(ROWS - 1);
    localparam logic [9:0] c_LAST_COL = 10'(COLS - 1);

    typedef enum logic [0:0] {
        c_ST_IDLE  = 1'b0,
        c_ST_CLEAR = 1'b1
    } state_t;

    state_t     r_state_q, w_state_d;
    logic [8:0] r_clr_row_q, w_clr_row_d;
    logic [9:0] r_clr_col_q, w_clr_col_d;
    logic [7:0] r_clr_color_q, w_clr_color_d;
    logic       w_clr_issue;
`endif

    assign wr_ready    = (r_level_q != c_DEPTH);
    assign w_xfer      = wr_valid & wr_ready;
    assign w_in_range  = (wr_row < c_ROWS) && (wr_col < c_COLS);
    assign w_push      = w_xfer & w_in_range;
    assign w_drop      = w_xfer & ~w_in_range;
    assign w_head      = r_fifo_mem[r_rd_ptr_q];

    // Port arbitration: display read, then clear sweep, then buffered write.
    always_comb begin
        w_pop         = 1'b0;
        w_mem_we_d    = 1'b0;
        w_mem_row_d   = r_mem_row_q;
        w_mem_col_d   = r_mem_col_q;
        w_mem_wdata_d = r_mem_wdata_q;
`ifdef VRAM_ARBITER_CLEAR_EN
        w_clr_issue   = 1'b0;
`endif
        if (disp_req) begin
            w_mem_row_d = disp_row;
            w_mem_col_d = disp_col;
        end
`ifdef VRAM_ARBITER_CLEAR_EN
        else if (r_state_q == c_ST_CLEAR) begin
            w_clr_issue   = 1'b1;
            w_mem_we_d    = 1'b1;
            w_mem_row_d   = r_clr_row_q;
            w_mem_col_d   = r_clr_col_q;
            w_mem_wdata_d = r_clr_color_q;
        end
`endif
        else if (r_level_q != 5'd0) begin
            w_pop         = 1'b1;
            w_mem_we_d    = 1'b1;
            w_mem_row_d   = w_head[26:18];
            w_mem_col_d   = w_head[17:8];
            w_mem_wdata_d = w_head[7:0];
        end
    end

    always_comb begin
        w_level_d       = r_level_q + {4'd0, w_push} - {4'd0, w_pop};
        w_wr_ptr_d      = w_push ? r_wr_ptr_q + c_PTR_ONE : r_wr_ptr_q;
        w_rd_ptr_d      = w_pop  ? r_rd_ptr_q + c_PTR_ONE : r_rd_ptr_q;
        w_drop_d        = (w_drop && (r_drop_q != 8'hFF)) ? r_drop_q + 8'd1 : r_drop_q;
        w_rd_v1_d       = disp_req;
        w_rd_v2_d       = r_rd_v1_q;
        w_d_out_valid_d = r_rd_v2_q;
        // RGB332 to 4:4:4 by replicating the top bits into the missing LSBs.
        w_d_out_d       = r_rd_v2_q ? {mem_rdata[1:0], mem_rdata[1:0],
                                       mem_rdata[4:2], mem_rdata[4],
                                       mem_rdata[7:5], mem_rdata[7]}
                                    : r_d_out_q;
    end

    always_ff @(posedge vga_clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr_q] <= {wr_row, wr_col, wr_data};
        end
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr_q      <= '0;
            r_rd_ptr_q      <= '0;
            r_level_q       <= 5'd0;
            r_drop_q        <= 8'd0;
            r_rd_v1_q       <= 1'b0;
            r_rd_v2_q       <= 1'b0;
            r_d_out_q       <= 12'd0;
            r_d_out_valid_q <= 1'b0;
            r_mem_row_q     <= 9'd0;
            r_mem_col_q     <= 10'd0;
            r_mem_we_q      <= 1'b0;
            r_mem_wdata_q   <= 8'd0;
        end else begin
            r_wr_ptr_q      <= w_wr_ptr_d;
            r_rd_ptr_q      <= w_rd_ptr_d;
            r_level_q       <= w_level_d;
            r_drop_q        <= w_drop_d;
            r_rd_v1_q       <= w_rd_v1_d;
            r_rd_v2_q       <= w_rd_v2_d;
            r_d_out_q       <= w_d_out_d;
            r_d_out_valid_q <= w_d_out_valid_d;
            r_mem_row_q     <= w_mem_row_d;
            r_mem_col_q     <= w_mem_col_d;
            r_mem_we_q      <= w_mem_we_d;
            r_mem_wdata_q   <= w_mem_wdata_d;
        end
    end

`ifdef VRAM_ARBITER_CLEAR_EN
    // Raster sweep, column fastest; the last pixel returns the engine to IDLE.
    always_comb begin
        w_state_d     = r_state_q;
        w_clr_row_d   = r_clr_row_q;
        w_clr_col_d   = r_clr_col_q;
        w_clr_color_d = r_clr_color_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (clr_start) begin
                    w_state_d     = c_ST_CLEAR;
                    w_clr_color_d = clr_color;
                    w_clr_row_d   = 9'd0;
                    w_clr_col_d   = 10'd0;
                end
            end
            c_ST_CLEAR: begin
                if (w_clr_issue) begin
                    if (r_clr_col_q == c_LAST_COL) begin
                        w_clr_col_d = 10'd0;
                        if (r_clr_row_q == c_LAST_ROW) begin
                            w_state_d = c_ST_IDLE;
                        end else begin
                            w_clr_row_d = r_clr_row_q + 9'd1;
                        end
                    end else begin
                        w_clr_col_d = r_clr_col_q + 10'd1;
                    end
                end
            end
            default: w_state_d = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= c_ST_IDLE;
            r_clr_row_q   <= 9'd0;
            r_clr_col_q   <= 10'd0;
            r_clr_color_q <= 8'd0;
        end else begin
            r_state_q     <= w_state_d;
            r_clr_row_q   <= w_clr_row_d;
            r_clr_col_q   <= w_clr_col_d;
            r_clr_color_q <= w_clr_color_d;
        end
    end

    assign clr_busy = (r_state_q == c_ST_CLEAR);
`endif

    assign d_out       = r_d_out_q;
    assign d_out_valid = r_d_out_valid_q;
    assign mem_row     = r_mem_row_q;
    assign mem_col     = r_mem_col_q;
    assign mem_we      = r_mem_we_q;
    assign mem_wdata   = r_mem_wdata_q;
    assign fifo_level  = r_level_q;
    assign drop_cnt    = r_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Directed self-checking bench for vram_arbiter (read pipeline,
//            write buffer, range drops, reset, optional clear engine).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;
`ifdef VRAM_ARBITER_CLEAR_EN
    localparam int TB_ROWS = 2;
    localparam int TB_COLS = 3;
`else
    localparam int TB_ROWS = 480;
    localparam int TB_COLS = 640;
`endif

    logic        vga_clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_req = 1'b0;
    logic [8:0]  disp_row = '0;
    logic [9:0]  disp_col = '0;
    logic [11:0] d_out;
    logic        d_out_valid;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [8:0]  wr_row = '0;
    logic [9:0]  wr_col = '0;
    logic [7:0]  wr_data = '0;
    logic [8:0]  mem_row;
    logic [9:0]  mem_col;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic [4:0]  fifo_level;
    logic [7:0]  drop_cnt;
`ifdef VRAM_ARBITER_CLEAR_EN
    logic        clr_start = 1'b0;
    logic [7:0]  clr_color = '0;
    logic        clr_busy;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    vram_arbiter #(.ROWS(TB_ROWS), .COLS(TB_COLS), .FIFO_DEPTH(4)) dut (
        .vga_clk     (vga_clk),
        .rst         (rst),
`ifdef VRAM_ARBITER_CLEAR_EN
        .clr_start   (clr_start),
        .clr_color   (clr_color),
        .clr_busy    (clr_busy),
`endif
        .disp_req    (disp_req),
        .disp_row    (disp_row),
        .disp_col    (disp_col),
        .d_out       (d_out),
        .d_out_valid (d_out_valid),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .mem_row     (mem_row),
        .mem_col     (mem_col),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .fifo_level  (fifo_level),
        .drop_cnt    (drop_cnt)
    );

    always #5 vga_clk = ~vga_clk;

    // Frame-buffer stand-in: data for (5,7) is 8'hAE, (2,3) is 8'hDA, (0,0) is 8'hF9.
    always @(posedge vga_clk) mem_rdata <= {mem_row[3:0], mem_col[3:0]} ^ 8'hF9;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic drive_wr(input logic v, input logic [8:0] r, input logic [9:0] c, input logic [7:0] d);
        wr_valid = v;
        wr_row   = r;
        wr_col   = c;
        wr_data  = d;
    endtask

    logic [8:0] e_row [4];
    logic [9:0] e_col [4];
    logic [7:0] e_dat [4];

    initial begin
        int we_seen;
        int vld_seen;
        e_row = '{9'd0, 9'd0, 9'd1, 9'd1};
        e_col = '{10'd0, 10'd1, 10'd2, 10'd0};
        e_dat = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset state
        repeat (2) tick();
        check_val("rst_mem_we", 32'(mem_we), 32'd0);
        check_val("rst_level", 32'(fifo_level), 32'd0);
        check_val("rst_drop", 32'(drop_cnt), 32'd0);
        check_val("rst_d_out", 32'(d_out), 32'd0);
        check_val("rst_d_valid", 32'(d_out_valid), 32'd0);
        rst = 1'b0;
        tick();
        check_val("ready_after_rst", 32'(wr_ready), 32'd1);

        // Single read: (5,7) -> 8'hAE -> 12'hA6B at T+3
        disp_req = 1'b1; disp_row = 9'd5; disp_col = 10'd7;
        tick();
        disp_req = 1'b0;
        check_val("rd_addr_we", 32'(mem_we), 32'd0);
        check_val("rd_addr_row", 32'(mem_row), 32'd5);
        check_val("rd_addr_col", 32'(mem_col), 32'd7);
        tick();
        check_val("rd_t2_valid", 32'(d_out_valid), 32'd0);
        tick();
        check_val("rd_t3_valid", 32'(d_out_valid), 32'd1);
        check_val("rd_t3_data", 32'(d_out), 32'hA6B);
        tick();
        check_val("rd_t4_valid", 32'(d_out_valid), 32'd0);
        check_val("rd_t4_hold", 32'(d_out), 32'hA6B);

        // Back-to-back reads: (2,3) -> 12'hADD, (0,0) -> 12'h5DF
        disp_req = 1'b1; disp_row = 9'd2; disp_col = 10'd3;
        tick();
        disp_row = 9'd0; disp_col = 10'd0;
        tick();
        disp_req = 1'b0;
        tick();
        check_val("b2b_0_data", 32'(d_out), 32'hADD);
        check_val("b2b_0_valid", 32'(d_out_valid), 32'd1);
        tick();
        check_val("b2b_1_data", 32'(d_out), 32'h5DF);
        check_val("b2b_1_valid", 32'(d_out_valid), 32'd1);
        tick();
        check_val("b2b_end_valid", 32'(d_out_valid), 32'd0);

        // Fill buffer while the display holds the port
        disp_req = 1'b1; disp_row = 9'd7; disp_col = 10'd9;
        for (int i = 0; i < 4; i++) begin
            drive_wr(1'b1, e_row[i], e_col[i], e_dat[i]);
            tick();
            check_val($sformatf("fill_we_%0d", i), 32'(mem_we), 32'd0);
        end
        drive_wr(1'b0, 9'd0, 10'd0, 8'd0);
        check_val("fill_level", 32'(fifo_level), 32'd4);
        check_val("fill_ready", 32'(wr_ready), 32'd0);
        tick();
        check_val("fill_hold_level", 32'(fifo_level), 32'd4);
        check_val("fill_hold_we", 32'(mem_we), 32'd0);
        disp_req = 1'b0;
        check_val("full_ready_pop_cycle", 32'(wr_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("drain_we_%0d", i), 32'(mem_we), 32'd1);
            check_val($sformatf("drain_row_%0d", i), 32'(mem_row), 32'(e_row[i]));
            check_val($sformatf("drain_col_%0d", i), 32'(mem_col), 32'(e_col[i]));
            check_val($sformatf("drain_dat_%0d", i), 32'(mem_wdata), 32'(e_dat[i]));
            check_val($sformatf("drain_level_%0d", i), 32'(fifo_level), 32'(3 - i));
        end
        tick();
        check_val("drain_idle_we", 32'(mem_we), 32'd0);
        check_val("drain_idle_row", 32'(mem_row), 32'(e_row[3]));
        check_val("drain_idle_dat", 32'(mem_wdata), 32'h44);

        // Out-of-range writes
        drive_wr(1'b1, 9'(TB_ROWS), 10'd0, 8'h77);
        tick();
        drive_wr(1'b0, 9'd0, 10'd0, 8'd0);
        check_val("drop_row_cnt", 32'(drop_cnt), 32'd1);
        check_val("drop_row_level", 32'(fifo_level), 32'd0);
        tick();
        check_val("drop_row_we", 32'(mem_we), 32'd0);
        drive_wr(1'b1, 9'd0, 10'(TB_COLS), 8'h77);
        tick();
        check_val("drop_col_cnt", 32'(drop_cnt), 32'd2);
        drive_wr(1'b1, 9'(TB_ROWS), 10'd0, 8'h77);
        repeat (298) tick();
        check_val("drop_sat_255", 32'(drop_cnt), 32'd255);
        tick();
        drive_wr(1'b0, 9'd0, 10'd0, 8'd0);
        check_val("drop_sat_hold", 32'(drop_cnt), 32'd255);
        check_val("drop_sat_level", 32'(fifo_level), 32'd0);

        // Last in-range pixel is accepted
        drive_wr(1'b1, 9'(TB_ROWS - 1), 10'(TB_COLS - 1), 8'h5A);
        tick();
        drive_wr(1'b0, 9'd0, 10'd0, 8'd0);
        check_val("edge_level", 32'(fifo_level), 32'd1);
        tick();
        check_val("edge_we", 32'(mem_we), 32'd1);
        check_val("edge_row", 32'(mem_row), 32'(TB_ROWS - 1));
        check_val("edge_col", 32'(mem_col), 32'(TB_COLS - 1));
        check_val("edge_dat", 32'(mem_wdata), 32'h5A);

        // Simultaneous push and pop at level 2
        disp_req = 1'b1;
        drive_wr(1'b1, 9'd0, 10'd1, 8'hA1); tick();
        drive_wr(1'b1, 9'd1, 10'd0, 8'hB2); tick();
        check_val("pp_pre_level", 32'(fifo_level), 32'd2);
        disp_req = 1'b0;
        drive_wr(1'b1, 9'd1, 10'd1, 8'hC3);
        tick();
        drive_wr(1'b0, 9'd0, 10'd0, 8'd0);
        check_val("pp_level", 32'(fifo_level), 32'd2);
        check_val("pp_dat_0", 32'(mem_wdata), 32'hA1);
        tick();
        check_val("pp_dat_1", 32'(mem_wdata), 32'hB2);
        check_val("pp_row_1", 32'(mem_row), 32'd1);
        tick();
        check_val("pp_dat_2", 32'(mem_wdata), 32'hC3);
        check_val("pp_we_2", 32'(mem_we), 32'd1);
        check_val("pp_end_level", 32'(fifo_level), 32'd0);

        // Reset mid-operation with three buffered writes and reads in flight
        disp_req = 1'b1; disp_row = 9'd7; disp_col = 10'd9;
        for (int i = 0; i < 3; i++) begin
            drive_wr(1'b1, 9'd0, 10'(i), 8'(i + 1));
            tick();
        end
        drive_wr(1'b0, 9'd0, 10'd0, 8'd0);
        check_val("mid_level", 32'(fifo_level), 32'd3);
        check_val("mid_d_out", 32'(d_out), 32'h009);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_d_out", 32'(d_out), 32'd0);
        check_val("arst_valid", 32'(d_out_valid), 32'd0);
        check_val("arst_we", 32'(mem_we), 32'd0);
        check_val("arst_row", 32'(mem_row), 32'd0);
        check_val("arst_col", 32'(mem_col), 32'd0);
        check_val("arst_wdata", 32'(mem_wdata), 32'd0);
        check_val("arst_level", 32'(fifo_level), 32'd0);
        check_val("arst_drop", 32'(drop_cnt), 32'd0);
        disp_req = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check_val("post_rst_ready", 32'(wr_ready), 32'd1);
        we_seen = 0;
        vld_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_we) we_seen++;
            if (d_out_valid) vld_seen++;
            tick();
        end
        check_val("post_rst_no_we", 32'(we_seen), 32'd0);
        check_val("post_rst_no_valid", 32'(vld_seen), 32'd0);

`ifdef VRAM_ARBITER_CLEAR_EN
        // Clear sweep over a 2x3 frame
        begin
            int busy_cnt;
            int wr_idx;
            busy_cnt = 0;
            wr_idx   = 0;
            clr_color = 8'h1C;
            clr_start = 1'b1;
            tick();
            clr_start = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (clr_busy) busy_cnt++;
                if (mem_we) begin
                    check_val($sformatf("clr_row_%0d", wr_idx), 32'(mem_row), 32'(wr_idx / TB_COLS));
                    check_val($sformatf("clr_col_%0d", wr_idx), 32'(mem_col), 32'(wr_idx % TB_COLS));
                    check_val($sformatf("clr_dat_%0d", wr_idx), 32'(mem_wdata), 32'h1C);
                    wr_idx++;
                end
                tick();
            end
            check_val("clr_busy_cycles", 32'(busy_cnt), 32'd6);
            check_val("clr_write_count", 32'(wr_idx), 32'd6);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ROWS, default 480, frame height in pixels.
REQ-002 Parameter COLS, default 640, frame width in pixels.
REQ-003 Parameter FIFO_DEPTH, default 4, write buffer entries, power of two, 2..16.
REQ-004 vga_clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 disp_req  in  1  display read request this cycle.
REQ-007 disp_row  in  9 / disp_col  in  10  display read coordinates.
REQ-008 d_out  out  12  expanded pixel: [11:8] B, [7:4] G, [3:0] R.
REQ-009 d_out_valid  out  1  d_out carries a pixel requested 3 cycles earlier.
REQ-010 wr_valid  in  1 / wr_ready  out  1  pixel-write handshake.
REQ-011 wr_row  in  9 / wr_col  in  10 / wr_data  in  8  write coordinates and RGB332 pixel: [7:5] R, [4:2] G, [1:0] B.
REQ-012 mem_row  out  9 / mem_col  out  10 / mem_we  out  1 / mem_wdata  out  8  registered frame-buffer port.
REQ-013 mem_rdata  in  8  frame-buffer read data, valid one cycle after the mem_* address cycle.
REQ-014 fifo_level  out  5  current write-buffer occupancy.
REQ-015 drop_cnt  out  8  saturating count of dropped out-of-range writes.

Function
REQ-016 One memory access per cycle; disp_req always wins; the write buffer, or the clear engine when present, gets the port only in cycles with disp_req low.
REQ-017 Read pipeline: disp_req at cycle T drives mem_row/mem_col with mem_we=0 at T+1, captures mem_rdata at T+2, presents d_out with d_out_valid=1 at T+3.
REQ-018 Expansion: R = {r[2:0], r[2]}, G = {g[2:0], g[2]}, B = {b[1:0], b[1:0]}.
REQ-019 d_out holds its last value when d_out_valid is 0.
REQ-020 Handshake: a write transfers when wr_valid and wr_ready are both high.
REQ-021 wr_ready = (fifo_level != FIFO_DEPTH), derived from registered state only; a pop in the same cycle does not raise it.
REQ-022 Range check: a transfer with wr_row >= ROWS or wr_col >= COLS is not buffered; drop_cnt increments and saturates at 255.
REQ-023 Buffer order: entries pop FIFO-order, one per free cycle, driving mem_we=1 with that entry's row, col and data at the next cycle.
REQ-024 Simultaneous push and pop: allowed whenever not full; fifo_level unchanged.
REQ-025 Buffer pointers wrap modulo FIFO_DEPTH.
REQ-026 mem_we is 0 in any cycle with no write issued; mem_row, mem_col and mem_wdata then hold their previous values.

Reset
REQ-027 rst asynchronously clears d_out, d_out_valid, mem_we, mem_row, mem_col, mem_wdata, fifo_level, drop_cnt and the buffer pointers to 0, and sets the clear engine to IDLE.
REQ-028 Reset discards buffered writes and reads in flight.
REQ-029 wr_ready is 1 from the first cycle after rst deasserts.

Configuration
REQ-030 Macro VRAM_ARBITER_CLEAR_EN, when defined, adds ports clr_start in 1, clr_color in 8 and clr_busy out 1, plus a clear engine.
REQ-031 Clear engine states: IDLE and CLEAR.
REQ-032 IDLE->CLEAR on clr_start: latches clr_color, sets the sweep counter to (0,0) and raises clr_busy.
REQ-033 In CLEAR the engine issues one write per free cycle in raster order with column fastest, taking priority over the write buffer; the buffer keeps accepting writes until full.
REQ-034 After writing (ROWS-1, COLS-1) the engine returns to IDLE and drops clr_busy in the same cycle that write is issued.
REQ-035 clr_start is ignored while in CLEAR.
REQ-036 Without VRAM_ARBITER_CLEAR_EN the ports and engine are absent, and writes come only from the buffer.

Verification
REQ-037 Read: disp_req=1, row 5, col 7, mem_rdata=8'b101_011_10 -> at T+3 d_out=12'hA_6_B, d_out_valid=1.
REQ-038 Fill: disp_req held high, 4 writes pushed -> fifo_level=4, wr_ready=0, mem_we stays 0; drop disp_req -> 4 writes issue in push order on 4 consecutive cycles.
REQ-039 Range: write to row 480, col 0 -> no mem_we, drop_cnt=1; 300 such writes -> drop_cnt=255.
REQ-040 Same cycle push and pop with fifo_level=2 -> fifo_level stays 2, data order preserved.
REQ-041 Reset mid-operation: rst with fifo_level=3 -> all outputs 0, no later mem_we for the discarded entries.
REQ-042 With VRAM_ARBITER_CLEAR_EN, ROWS=2, COLS=3, clr_color=8'h1C, no disp_req -> 6 writes in raster order (0,0)..(1,2), clr_busy high for exactly 6 cycles.
